// File: rtl/spi_shift_reg.sv
// ============================================================================
// Module   : spi_shift_reg
// Brief    : SPI master data shift stage. It launches and samples bits on the
//            clock-generator strobes and drives the tip/last_clk handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_shift_reg #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 5
) (
  input  logic              wb_clk_in,
  input  logic              wb_rst,
  input  logic              go,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic [LEN_W-1:0]  len,
  input  logic              lsb,
  input  logic              tx_negedge,
  input  logic              rx_negedge,
  input  logic              cpol_0,
  input  logic              cpol_1,
  input  logic              miso,
  output logic              tip,
  output logic              last_clk,
  output logic              mosi,
  output logic [DATA_W-1:0] data_out,
  output logic              done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  localparam logic [LEN_W:0] FULL_N = (LEN_W+1)'(DATA_W);
  localparam logic [LEN_W:0] ONE    = (LEN_W+1)'(1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [LEN_W:0]      n_q, n_d;
  logic [LEN_W:0]      rem_q, rem_d;
  logic [LEN_W:0]      k_q, k_d;
  logic [LEN_W:0]      j_q, j_d;
  logic                lsb_q, lsb_d;
  logic                txn_q, txn_d;
  logic                rxn_q, rxn_d;
  logic                last_clk_q, last_clk_d;
  logic                mosi_q, mosi_d;
  logic                done_q, done_d;

  logic                tx_strobe, rx_strobe;
  logic [LEN_W:0]      n_new;

  // Sequence index i maps to word bit i (LSB first) or N-1-i (MSB first).
  function automatic logic [LEN_W-1:0] bit_pos(input logic [LEN_W:0] i,
                                               input logic [LEN_W:0] n,
                                               input logic           lsb_first);
    logic [LEN_W:0] p;
    p = lsb_first ? i : (n - i - ONE);
    return p[LEN_W-1:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    data_out_d = data_out_q;
    n_d        = n_q;
    rem_d      = rem_q;
    k_d        = k_q;
    j_d        = j_q;
    lsb_d      = lsb_q;
    txn_d      = txn_q;
    rxn_d      = rxn_q;
    mosi_d     = mosi_q;
    done_d     = 1'b0;
    tx_strobe  = txn_q ? cpol_1 : cpol_0;
    rx_strobe  = rxn_q ? cpol_1 : cpol_0;
    n_new      = (len == '0) ? FULL_N : {1'b0, len};

    case (state_q)
      S_IDLE: begin
        if (load) begin
          tx_d = data_in;
        end
        if (go) begin
          state_d    = S_XFER;
          n_d        = n_new;
          rem_d      = n_new;
          lsb_d      = lsb;
          txn_d      = tx_negedge;
          rxn_d      = rx_negedge;
          k_d        = '0;
          j_d        = '0;
          data_out_d = '0;
          // Falling-edge launch needs bit 0 on the line before the first rise.
          if (tx_negedge) begin
            mosi_d = tx_d[bit_pos('0, n_new, lsb)];
            k_d    = ONE;
          end
        end
      end
      default: begin
        if (tx_strobe && (k_q < n_q)) begin
          mosi_d = tx_q[bit_pos(k_q, n_q, lsb_q)];
          k_d    = k_q + ONE;
        end
        if (rx_strobe && (j_q < n_q)) begin
          data_out_d[bit_pos(j_q, n_q, lsb_q)] = miso;
          j_d = j_q + ONE;
        end
        if (cpol_0 && (rem_q != '0)) begin
          rem_d = rem_q - ONE;
        end
        if (cpol_1 && last_clk_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase

    // Computed from next-state values so it lands with the final SCLK rise.
    last_clk_d = (state_d == S_XFER) && (rem_d == '0);
  end

  always_ff @(posedge wb_clk_in or posedge wb_rst) begin
    if (wb_rst) begin
      state_q    <= S_IDLE;
      tx_q       <= '0;
      data_out_q <= '0;
      n_q        <= '0;
      rem_q      <= '0;
      k_q        <= '0;
      j_q        <= '0;
      lsb_q      <= 1'b0;
      txn_q      <= 1'b0;
      rxn_q      <= 1'b0;
      last_clk_q <= 1'b0;
      mosi_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      data_out_q <= data_out_d;
      n_q        <= n_d;
      rem_q      <= rem_d;
      k_q        <= k_d;
      j_q        <= j_d;
      lsb_q      <= lsb_d;
      txn_q      <= txn_d;
      rxn_q      <= rxn_d;
      last_clk_q <= last_clk_d;
      mosi_q     <= mosi_d;
      done_q     <= done_d;
    end
  end

  assign tip      = (state_q == S_XFER);
  assign last_clk = last_clk_q;
  assign mosi     = mosi_q;
  assign data_out = data_out_q;
  assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_shift_reg.sv
// ============================================================================
// Module   : tb_spi_shift_reg
// Brief    : Scoreboard bench for spi_shift_reg with a behavioural SCLK generator.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_shift_reg;

  localparam int DIV = 1;

  logic        clk = 1'b0;
  logic        wb_rst, go, load, lsb, tx_negedge, rx_negedge;
  logic        cpol_0, cpol_1, miso, tip, last_clk, mosi, done;
  logic [31:0] data_in, data_out;
  logic [4:0]  len;

  always #5 clk = ~clk;

  spi_shift_reg #(.DATA_W(32), .LEN_W(5)) dut (
    .wb_clk_in (clk),
    .wb_rst    (wb_rst),
    .go        (go),
    .load      (load),
    .data_in   (data_in),
    .len       (len),
    .lsb       (lsb),
    .tx_negedge(tx_negedge),
    .rx_negedge(rx_negedge),
    .cpol_0    (cpol_0),
    .cpol_1    (cpol_1),
    .miso      (miso),
    .tip       (tip),
    .last_clk  (last_clk),
    .mosi      (mosi),
    .data_out  (data_out),
    .done      (done)
  );

  // Serial clock generator model: stops rising once last_clk is up.
  logic sclk;
  int   gcnt;
  assign cpol_0 = tip && (gcnt == 0) && !sclk && !last_clk;
  assign cpol_1 = tip && (gcnt == 0) && sclk;

  always @(posedge clk or posedge wb_rst) begin
    if (wb_rst || !tip) begin
      sclk <= 1'b0;
      gcnt <= DIV;
    end else if (gcnt == 0) begin
      gcnt <= DIV;
      if (cpol_0) sclk <= 1'b1;
      if (cpol_1) sclk <= 1'b0;
    end else begin
      gcnt <= gcnt - 1;
    end
  end

  // External MISO source: pattern bit per RX strobe, or loopback.
  logic        use_loop;
  logic [31:0] pat;
  logic [5:0]  rx_idx;
  assign miso = use_loop ? mosi : pat[rx_idx[4:0]];

  always @(posedge clk) begin
    if (wb_rst || (go && !tip)) rx_idx <= '0;
    else if (tip && (rx_negedge ? cpol_1 : cpol_0)) rx_idx <= rx_idx + 6'd1;
  end

  typedef struct {
    logic [31:0] data;
    logic [31:0] seq;
    int          n;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: counts strobes, captures the launched MOSI sequence, checks on done.
  int          rises, falls, ncap;
  logic [31:0] capw;
  logic        prev_lc;
  exp_t        e_pop;

  always @(negedge clk) begin
    if (wb_rst) begin
      rises = 0; falls = 0; ncap = 0; capw = '0; prev_lc = 1'b0;
    end else begin
      if (go && !tip) begin
        rises = 0; falls = 0; ncap = 0; capw = '0;
      end
      if (last_clk && !prev_lc && sb.size() > 0) begin
        chk("lc_rise_sclk_high", {31'd0, sclk}, 32'd1);
        chk("lc_rise_count", 32'(rises), 32'(sb[0].n));
      end
      prev_lc = last_clk;
      if (tip) begin
        if (cpol_0) rises++;
        if (cpol_1) falls++;
        if ((tx_negedge ? cpol_0 : cpol_1) && ncap < 32) begin
          capw[ncap] = mosi;
          ncap++;
        end
      end
      if (done) begin
        chk("done_expected", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          e_pop = sb.pop_front();
          chk("data_out", data_out, e_pop.data);
          chk("mosi_seq", capw, e_pop.seq);
          chk("rise_count", 32'(rises), 32'(e_pop.n));
          chk("fall_count", 32'(falls), 32'(e_pop.n));
          chk("tip_low_at_done", {31'd0, tip}, 32'd0);
          chk("last_clk_low_at_done", {31'd0, last_clk}, 32'd0);
          chk("sclk_low_at_done", {31'd0, sclk}, 32'd0);
        end
      end
    end
  end

  task automatic xfer(input logic [31:0] d, input logic ld, input logic [4:0] l,
                      input logic lf, input logic tn, input logic rn, input logic lp,
                      input logic [31:0] p, input logic [31:0] exp_d,
                      input logic [31:0] exp_s, input int inject);
    exp_t e;
    lsb = lf; tx_negedge = tn; rx_negedge = rn; use_loop = lp; pat = p;
    len = l; data_in = d; load = ld; go = 1'b1;
    e.data = exp_d; e.seq = exp_s; e.n = (l == 5'd0) ? 32 : int'(l);
    sb.push_back(e);
    @(posedge clk); #1;
    go = 1'b0; load = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (inject > 0 && c == inject) begin
        data_in = 32'hFF; load = 1'b1; go = 1'b1;
      end
      if (inject > 0 && c == inject + 1) begin
        load = 1'b0; go = 1'b0;
      end
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("xfer_completes", 32'(sb.size()), 32'd0);
    if (sb.size() != 0) sb.delete();
    load = 1'b0; go = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wb_rst = 1'b1; go = 1'b0; load = 1'b0; data_in = '0; len = '0;
    lsb = 1'b0; tx_negedge = 1'b0; rx_negedge = 1'b0; use_loop = 1'b1; pat = '0;
    repeat (3) @(posedge clk);
    #1 wb_rst = 1'b0;
    @(negedge clk);
    chk("rst_tip", {31'd0, tip}, 32'd0);
    chk("rst_last_clk", {31'd0, last_clk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    @(posedge clk); #1;

    // Mode 0, MSB first, load together with go, loopback.
    xfer(32'hA5, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hA5, 32'hA5, 0);

    // LSB first, len 4, MISO pattern 0,1,1,0, every tx/rx edge combination.
    for (int m = 0; m < 4; m++) begin
      data_in = 32'h3; load = 1'b1;
      @(posedge clk); #1 load = 1'b0;
      xfer(32'h0, 1'b0, 5'd4, 1'b1, m[1], m[0], 1'b0, 32'h6, 32'h6, 32'h3, 0);
    end

    // Full 32-bit word, MSB first.
    xfer(32'hDEADBEEF, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,
         32'hDEADBEEF, 32'hF77DB57B, 0);

    // go/load during the transfer must be ignored, and must not touch the TX word.
    xfer(32'hA5, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hA5, 32'hA5, 5);
    xfer(32'h0, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hA5, 32'hA5, 0);

    // Reset after three bits: immediate abort, no done.
    data_in = 32'hA5; load = 1'b1; go = 1'b1; len = 5'd8; lsb = 1'b0;
    tx_negedge = 1'b1; rx_negedge = 1'b0; use_loop = 1'b1;
    @(posedge clk); #1 go = 1'b0; load = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (rises >= 3) break;
      @(posedge clk); #1;
    end
    chk("abort_reached_3_bits", {31'd0, rises >= 3}, 32'd1);
    wb_rst = 1'b1;
    #1;
    chk("abort_tip", {31'd0, tip}, 32'd0);
    chk("abort_last_clk", {31'd0, last_clk}, 32'd0);
    chk("abort_mosi", {31'd0, mosi}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_data_out", data_out, 32'd0);
    @(posedge clk); #1 wb_rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    xfer(32'h3C, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h3C, 32'h3C, 0);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
